// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage issuer and muldiv_unit.
// The master drives operands and start; the slave returns busy/done/result/rd_out.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 4
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [AW-1:0]    rd_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [AW-1:0]    rd_out;

   modport master (
      output start, op, a, b, rd_in,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, op, a, b, rd_in,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle over WIDTH cycles, registered result with a one-cycle done strobe.
module muldiv_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 4
) (
   input logic           i_clk,
   input logic           i_rst,  // synchronous, active low
   muldiv_unit_if.slave  io_bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             r_state, w_state_next;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_b;
   logic [AW-1:0]      r_rd;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [AW-1:0]      r_rd_out;

   logic               w_last;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_prod_next;
   logic [WIDTH:0]     w_trial;
   logic               w_ge;
   logic [WIDTH:0]     w_rem_next;
   logic [WIDTH-1:0]   w_quo_next;
   logic [WIDTH-1:0]   w_result_next;
   logic               w_unused;

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // Multiply: add b into the upper half when the current LSB is set, then shift right.
   assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
   assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};

   // Restoring divide: r_quo shifts the dividend out MSB first and quotient bits in.
   assign w_trial    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_ge       = (w_trial >= {1'b0, r_b});
   assign w_rem_next = w_ge ? (w_trial - {1'b0, r_b}) : w_trial;
   assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
   // Remainder stays below b, so its top bit never feeds the next trial.
   assign w_unused   = r_rem[WIDTH];

   always_comb begin
      w_result_next = w_prod_next[WIDTH-1:0];
      unique case (r_op)
         2'b00:   w_result_next = w_prod_next[WIDTH-1:0];
         2'b01:   w_result_next = w_prod_next[2*WIDTH-1:WIDTH];
         2'b10:   w_result_next = w_quo_next;
         2'b11:   w_result_next = w_rem_next[WIDTH-1:0];
         default: w_result_next = w_prod_next[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (io_bus.start) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_op     <= '0;
         r_b      <= '0;
         r_rd     <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_op   <= io_bus.op;
                  r_b    <= io_bus.b;
                  r_rd   <= io_bus.rd_in;
                  r_prod <= {{WIDTH{1'b0}}, io_bus.a};
                  r_rem  <= '0;
                  r_quo  <= io_bus.a;
                  r_cnt  <= '0;
               end
            end
            StRun: begin
               r_prod <= w_prod_next;
               r_rem  <= w_rem_next;
               r_quo  <= w_quo_next;
               r_cnt  <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_result_next;
                  r_rd_out <= r_rd;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.busy   = (r_state != StIdle);
   assign io_bus.done   = (r_state == StDone);
   assign io_bus.result = r_result;
   assign io_bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table driven through a scoreboard,
// plus reset, busy-input-change and mid-run reset sequences.
module tb_muldiv_unit;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned AW    = 4;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  rd;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] exp;
      logic [3:0]  rd;
      int          acc;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   sb_t  sb[$];
   vec_t vecs[12];

   muldiv_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   muldiv_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest accepted request.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         sb_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", {16'h0, bus.result}, {16'h0, e.exp});
            chk("rd_out", {28'h0, bus.rd_out}, {28'h0, e.rd});
            chk("latency", cyc - e.acc, 32'd16);
         end
      end
   end

   task automatic drive_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] rd);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.rd_in = rd;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk({name, "_timeout"}, sb.size(), 32'd0);
         sb.delete();
      end
      @(negedge clk);
      chk({name, "_busy_after_done"}, {31'h0, bus.busy}, 32'd0);
      chk({name, "_done_one_cycle"}, {31'h0, bus.done}, 32'd0);
   endtask

   task automatic run_op(input vec_t v);
      sb_t e;
      drive_start(v.op, v.a, v.b, v.rd);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_accept", {31'h0, bus.busy}, 32'd1);
      e.exp = v.exp;
      e.rd  = v.rd;
      e.acc = cyc;
      sb.push_back(e);
      wait_drain("op");
   endtask

   initial begin
      sb_t  e;
      vec_t v;
      int   dc;

      vecs[0]  = '{op: 2'b00, a: 16'h2150, b: 16'h0512, rd: 4'd9,  exp: 16'hE7A0};
      vecs[1]  = '{op: 2'b01, a: 16'h2150, b: 16'h0512, rd: 4'd9,  exp: 16'h00A8};
      vecs[2]  = '{op: 2'b00, a: 16'h1450, b: 16'h0003, rd: 4'd1,  exp: 16'h3CF0};
      vecs[3]  = '{op: 2'b10, a: 16'h1450, b: 16'h0010, rd: 4'd2,  exp: 16'h0145};
      vecs[4]  = '{op: 2'b11, a: 16'h1450, b: 16'h0007, rd: 4'd3,  exp: 16'h0006};
      vecs[5]  = '{op: 2'b10, a: 16'h2150, b: 16'h0000, rd: 4'd4,  exp: 16'hFFFF};
      vecs[6]  = '{op: 2'b11, a: 16'h2150, b: 16'h0000, rd: 4'd5,  exp: 16'h2150};
      vecs[7]  = '{op: 2'b00, a: 16'hFFFF, b: 16'hFFFF, rd: 4'd15, exp: 16'h0001};
      vecs[8]  = '{op: 2'b01, a: 16'hFFFF, b: 16'hFFFF, rd: 4'd14, exp: 16'hFFFE};
      vecs[9]  = '{op: 2'b10, a: 16'hFFFF, b: 16'h0001, rd: 4'd6,  exp: 16'hFFFF};
      vecs[10] = '{op: 2'b10, a: 16'h0005, b: 16'h0009, rd: 4'd7,  exp: 16'h0000};
      vecs[11] = '{op: 2'b11, a: 16'h0005, b: 16'h0009, rd: 4'd8,  exp: 16'h0005};

      // Reset held for two edges with start asserted.
      rst       = 1'b0;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 16'h1234;
      bus.b     = 16'h5678;
      bus.rd_in = 4'd5;
      repeat (2) begin
         @(negedge clk);
         chk("rst_busy", {31'h0, bus.busy}, 32'd0);
         chk("rst_done", {31'h0, bus.done}, 32'd0);
         chk("rst_result", {16'h0, bus.result}, 32'd0);
         chk("rst_rd_out", {28'h0, bus.rd_out}, 32'd0);
      end
      rst       = 1'b1;
      bus.start = 1'b0;

      for (int i = 0; i < 12; i++) run_op(vecs[i]);

      // Start and operand changes during RUN must be ignored.
      dc = done_cnt;
      drive_start(2'b00, 16'h2150, 16'h0512, 4'd9);
      @(negedge clk);
      e.exp = 16'hE7A0;
      e.rd  = 4'd9;
      e.acc = cyc;
      sb.push_back(e);
      for (int k = 0; k < 6; k++) begin
         bus.start = 1'b1;
         bus.op    = 2'($urandom_range(3));
         bus.a     = 16'($urandom);
         bus.b     = 16'($urandom);
         bus.rd_in = 4'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_drain("busy_ignore");
      chk("busy_single_done", done_cnt - dc, 32'd1);

      // Reset during iteration 8 aborts without a done pulse.
      dc = done_cnt;
      drive_start(2'b00, 16'h2150, 16'h0512, 4'd3);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort_busy", {31'h0, bus.busy}, 32'd0);
      repeat (25) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 32'd0);
      chk("abort_result_cleared", {16'h0, bus.result}, 32'd0);

      v = '{op: 2'b00, a: 16'h1450, b: 16'h0003, rd: 4'd11, exp: 16'h3CF0};
      run_op(v);
      chk("result_held", {16'h0, bus.result}, 32'h3CF0);
      chk("rd_out_held", {28'h0, bus.rd_out}, 32'd11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit unsigned multiply/divide unit in the execute stage, directly downstream of the register file. It takes the two read-port values (`Rout1`, `Rout2`) and a destination register index, and computes one of four results over a fixed number of cycles. It then presents the result, the destination index and a one-cycle write strobe, which the writeback path routes to the register file's `RW`, `Rd` and `wr` inputs.

## Interface
- `WIDTH`, 16: operand/result width; iteration count equals `WIDTH`.
- `AW`, 4: register index width (16 registers).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  2  00 MUL (product[15:0]), 01 MULH (product[31:16]), 10 DIVU (quotient), 11 REMU (remainder).
- `a`  in  WIDTH  first operand / dividend (from `Rout1`).
- `b`  in  WIDTH  second operand / divisor (from `Rout2`).
- `rd_in`  in  AW  destination register index.
- `busy`  out  1  high from accept edge through the DONE cycle.
- `done`  out  1  one-cycle strobe; drives register file `wr`.
- `result`  out  WIDTH  selected result; drives register file `RW`.
- `rd_out`  out  AW  latched `rd_in`; drives register file `Rd`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `a`, `b`, `op`, `rd_in`, clears the accumulator and iteration counter, and moves to RUN.
  - `start`=0 stays in IDLE.
- RUN: one iteration per cycle, counter 0..WIDTH-1. After the iteration with counter = WIDTH-1, move to DONE and register `result`.
- MUL/MULH use shift-add into a 2·WIDTH-bit product; unsigned, no overflow flag.
- DIVU/REMU use restoring division, one quotient bit per cycle, MSB first.
  - Remainder register is WIDTH+1 bits to hold the trial subtraction.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `result` and `rd_out` hold their values after DONE until the next DONE.
- Divide by zero gets no special path; the algorithm naturally yields quotient 0xFFFF and remainder = `a`, with normal latency.
- `start` in RUN or DONE is ignored; no queueing. Changes on `a`/`b`/`op`/`rd_in` after the accept edge have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x0000, `rd_out`=0, internal registers 0.
- Reset mid-operation (RUN or DONE): abort on that edge. No `done` pulse is produced and the partial result is discarded.
- Reset wins over a simultaneous `start`.

## Timing
- Accept edge E0: `busy`=1 visible after E0.
- Iterations occur on edges E1..E16; E16 enters DONE.
- `done`=1, `result` and `rd_out` are valid in the cycle between E16 and E17. The register file writes at E17.
- E17 returns to IDLE with `busy`=0. A new `start` is accepted at E18 at the earliest (`start` must be high before E18).
- Fixed latency of 16 cycles start-to-done for all ops and operands. Throughput is one operation per 18 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold `rst`=0 for 2 edges with `start`=1 -> `busy`=0, `done`=0, `result`=0x0000, `rd_out`=0 throughout.
- Multiply: `a`=0x2150, `b`=0x0512, MUL, `rd_in`=9 -> `done` exactly 16 cycles after the accept edge, `result`=0xE7A0, `rd_out`=9. Same operands with MULH -> 0x00A8. Also `a`=0x1450, `b`=0x0003, MUL -> 0x3CF0.
- Divide: `a`=0x1450, `b`=0x0010, DIVU -> 0x0145. `a`=0x1450, `b`=0x0007, REMU -> 0x0006.
- Divide by zero: `a`=0x2150, `b`=0x0000, DIVU -> 0xFFFF; same operands with REMU -> 0x2150, with normal latency.
- Busy behaviour: during RUN, assert `start` and change `a`/`b`/`rd_in` -> the result still matches the latched operands and exactly one `done` pulse occurs. `busy` falls one edge after `done`.
- Reset mid-run: drive `rst`=0 at iteration 8 -> `busy`=0 after that edge and no `done` ever pulses. Then MUL 0x1450×0x0003 -> 0x3CF0 with full latency.
